datapath_pipe: RTL and testbench
================================

# datapath_pipe

Parametrised two-stage pipelined datapath: an NREG×W register file, B-operand constant mux, a 16-function ALU/shifter, and a D-mux choosing between the ALU result and memory read data. Stage 1 reads operands and drives the memory address/data bus. Stage 2 executes and writes back, with one-level forwarding and a registered V/C/N/Z status register. It replaces the 4×4 single-cycle datapath as the execution core under the microsequencer, and keeps the same control-word field order.

## Interface
- W, 8: data width (≥2).
- NREG, 8: register count, power of 2 (≥2); AW = clog2(NREG).
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- CW_VALID  in  1  ControlWord is a real instruction this cycle.
- ControlWord  in  3AW+7  {DA, AA, BA, MB, FS[3:0], MD, RW}, MSB to LSB; RW is bit 0, MD bit 1, FS bits 5:2, MB bit 6.
- ConstantIn  in  W  immediate, sampled with ControlWord.
- DataIn  in  W  memory read data, sampled one cycle after its instruction (stage 2).
- AddressOut  out  W  registered stage-1 A operand.
- DataOut  out  W  registered stage-1 B-mux output.
- ADDR_VALID  out  1  stage-1 holds a valid instruction.
- WB_VALID  out  1  pulses in the cycle after a writeback edge.
- Status  out  4  {V, C, N, Z}, registered.
- RegFlat  out  NREG*W  register i at bits [i*W+W-1 : i*W].

## Operation
- **Stage 1 (edge t, if CW_VALID):**
  - Latch A = R[AA] and B = MB ? ConstantIn : R[BA].
  - Latch DA, FS, MD, RW. Set the stage-1 valid bit.
  - If CW_VALID=0, clear the valid bit; data registers hold.
- **Forwarding:** if stage 2 writes at the same edge (valid, RW=1) with DA2==AA (or DA2==BA with MB=0), stage 1 takes the D-mux value instead of the stale register.
- **Stage 2 (edge t+1, if stage-1 valid):**
  - Compute F = ALU(A, B, FS).
  - D = MD ? DataIn : F.
  - If RW=1, R[DA] <= D. RW=0 means no register change.
- **FS encoding:**
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1; 0100 A+~B; 0101 A+~B+1 (A−B); 0110 A−1; 0111 A.
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A; 1100 B; 1101 B>>1; 1110 B<<1; 1111 zero.
- **Arithmetic:**
  - Computed at W+1 bits. C = bit W (carry out; for A−1, C = carry of A+all-ones).
  - V = signed overflow of the W-bit operation.
- **Flags:**
  - Updated only at a stage-2 edge with valid and MD=0, regardless of RW.
  - Z = (F==0); N = F[W-1].
  - Logic ops and moves (0000, 0111, 1000–1100, 1111): C=0, V=0.
  - 1101: C=B[0], V=0. 1110: C=B[W-1], V=0.
  - MD=1 instructions leave Status unchanged.
- **Reset (RST=1 at an edge):**
  - All registers, AddressOut, DataOut, Status, ADDR_VALID and WB_VALID go to 0. Both pipeline valid bits are cleared.
  - Any in-flight instruction is discarded with no writeback or flag update. CW_VALID is ignored during reset.
- **Write-port conflicts:** only one write port exists (stage 2), so no conflicts are possible. Reading and writing the same register in one cycle is resolved by forwarding.

## Timing
- **Edge t:** instruction accepted. AddressOut, DataOut and ADDR_VALID are valid during cycle t→t+1.
- **DataIn:** must be stable before edge t+1 and is sampled there.
- **Edge t+1:** writeback and flags. RegFlat, Status and WB_VALID (=1 only if RW=1) reflect the result during cycle t+1→t+2.
- **Throughput:** one instruction per cycle, no stalls. Dependent back-to-back instructions see the correct value via forwarding.
- **Latency:** ControlWord to architectural register = 2 edges (t, t+1).
- **Reset values:** all outputs 0, from the first edge with RST=1.

## Test plan
- **Reset:** preload R3=0x5A, assert RST one edge mid-instruction → RegFlat=0, Status=0, ADDR_VALID=0, WB_VALID=0, and no write of the dropped instruction.
- **Immediate load + add (W=8):**
  - R1 <= const 0x7F (FS=1100, MB=1, RW=1).
  - R2 <= const 0x01.
  - R3 <= R1+R2.
  - Required: R3=0x80 two edges after issue, V=1, N=1, C=0, Z=0.
- **Forwarding chain:** R1<=const 5, then R1<=R1+1 on the next cycle, then R1<=R1+1 again → R1=7, with no bubble cycles.
- **Memory path:** issue AA=R1 (=0x10), MD=1, DA=R4. AddressOut=0x10 in the next cycle; drive DataIn=0xC3 before the following edge → R4=0xC3 and Status unchanged.
- **Subtract/shift flags:**
  - R1=0x03, R2=0x03, FS=0101 → F=0, Z=1, C=1, V=0.
  - B=0x81, FS=1110 → F=0x02, C=1.
  - FS=1101 with B=0x81 → F=0x40, C=1.
- **Parameters NREG=16, W=4:** write R15 then read via AA=15 → correct value; CW_VALID=0 cycles and RW=0 produce no writes and WB_VALID=0.

Source files
------------

// File: rtl/datapath_pipe_if.sv
// datapath_pipe_if: control, memory bus and status bundle of the pipelined datapath
interface datapath_pipe_if #(
    parameter int W    = 8,
    parameter int NREG = 8
);
    localparam int AW = $clog2(NREG);
    logic                CW_VALID;
    logic [3*AW+6:0]     ControlWord;
    logic [W-1:0]        ConstantIn;
    logic [W-1:0]        DataIn;
    logic [W-1:0]        AddressOut;
    logic [W-1:0]        DataOut;
    logic                ADDR_VALID;
    logic                WB_VALID;
    logic [3:0]          Status;
    logic [NREG*W-1:0]   RegFlat;
    modport master (
        output CW_VALID, ControlWord, ConstantIn, DataIn,
        input  AddressOut, DataOut, ADDR_VALID, WB_VALID, Status, RegFlat
    );
    modport slave (
        input  CW_VALID, ControlWord, ConstantIn, DataIn,
        output AddressOut, DataOut, ADDR_VALID, WB_VALID, Status, RegFlat
    );
endinterface

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage register-file/ALU datapath with forwarding and V/C/N/Z status
module datapath_pipe #(
    parameter int W    = 8,
    parameter int NREG = 8
) (
    input logic             CLK,
    input logic             RST,
    datapath_pipe_if.slave  bus
);
    localparam int AW = $clog2(NREG);
    logic [AW-1:0] da, aa, ba;
    logic          mb;
    assign {da, aa, ba, mb} = bus.ControlWord[3*AW+6:6];
    logic          v1_q, v1_d, md_q, md_d, rw_q, rw_d, wb_q, wb_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [AW-1:0] da_q, da_d;
    logic [3:0]    fs_q, fs_d, st_q, st_d;
    logic [W-1:0]  r_q [NREG];
    logic [W-1:0]  r_d [NREG];
    logic [W-1:0]  y, f, d;
    logic [W:0]    sum;
    logic          arith, c, v, we;
    // Codes 0001..0110 share one adder: A + y + cin, y picked from FS[2:1]
    always_comb begin
        arith = ~fs_q[3] && fs_q[2:0] != 3'd0 && fs_q[2:0] != 3'd7;
        y     = fs_q[2:1] == 2'b01 ? b_q : fs_q[2:1] == 2'b10 ? ~b_q : fs_q[2:1] == 2'b11 ? '1 : '0;
        sum   = {1'b0, a_q} + {1'b0, y} + (W+1)'(fs_q[0]);
        case (fs_q)
            4'b0000, 4'b0111: f = a_q;
            4'b1000:          f = a_q & b_q;
            4'b1001:          f = a_q | b_q;
            4'b1010:          f = a_q ^ b_q;
            4'b1011:          f = ~a_q;
            4'b1100:          f = b_q;
            4'b1101:          f = b_q >> 1;
            4'b1110:          f = b_q << 1;
            4'b1111:          f = '0;
            default:          f = sum[W-1:0];
        endcase
        c  = arith ? sum[W] : fs_q == 4'b1101 ? b_q[0] : fs_q == 4'b1110 ? b_q[W-1] : 1'b0;
        v  = arith && (a_q[W-1] == y[W-1]) && (f[W-1] != a_q[W-1]);
        d  = md_q ? bus.DataIn : f;
        we = v1_q & rw_q;
    end
    always_comb begin
        v1_d = bus.CW_VALID;
        a_d  = bus.CW_VALID ? (we && da_q == aa ? d : r_q[aa]) : a_q;
        b_d  = bus.CW_VALID ? (mb ? bus.ConstantIn : (we && da_q == ba ? d : r_q[ba])) : b_q;
        da_d = bus.CW_VALID ? da : da_q;
        fs_d = bus.CW_VALID ? bus.ControlWord[5:2] : fs_q;
        md_d = bus.CW_VALID ? bus.ControlWord[1] : md_q;
        rw_d = bus.CW_VALID ? bus.ControlWord[0] : rw_q;
        st_d = v1_q && !md_q ? {v, c, f[W-1], f == '0} : st_q;
        wb_d = we;
        r_d  = r_q;
        if (we) r_d[da_q] = d;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            da_q <= '0;
            fs_q <= '0;
            md_q <= 1'b0;
            rw_q <= 1'b0;
            st_q <= '0;
            wb_q <= 1'b0;
            r_q  <= '{default: '0};
        end else begin
            v1_q <= v1_d;
            a_q  <= a_d;
            b_q  <= b_d;
            da_q <= da_d;
            fs_q <= fs_d;
            md_q <= md_d;
            rw_q <= rw_d;
            st_q <= st_d;
            wb_q <= wb_d;
            r_q  <= r_d;
        end
    end
    assign bus.AddressOut = a_q;
    assign bus.DataOut    = b_q;
    assign bus.ADDR_VALID = v1_q;
    assign bus.WB_VALID   = wb_q;
    assign bus.Status     = st_q;
    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign bus.RegFlat[i*W +: W] = r_q[i];
    end
endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed vectors with a writeback scoreboard for two parameter sets
module tb_datapath_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    typedef struct {
        int         r;
        logic [7:0] v;
        logic [3:0] s;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];
    datapath_pipe_if #(.W(8), .NREG(8))  b1();
    datapath_pipe_if #(.W(4), .NREG(16)) b2();
    datapath_pipe #(.W(8), .NREG(8))  d1 (.CLK(clk), .RST(rst), .bus(b1));
    datapath_pipe #(.W(4), .NREG(16)) d2 (.CLK(clk), .RST(rst), .bus(b2));
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, act, req);
        end
    endtask
    task automatic op1(input logic [2:0] da, aa, ba, input logic mb, input logic [3:0] fs,
                       input logic md, rw, input logic [7:0] k, input bit push,
                       input logic [7:0] ev, input logic [3:0] es);
        @(negedge clk);
        b1.CW_VALID    = 1'b1;
        b1.ControlWord = {da, aa, ba, mb, fs, md, rw};
        b1.ConstantIn  = k;
        if (push) q1.push_back('{int'(da), ev, es});
    endtask
    task automatic op2(input logic [3:0] da, aa, ba, input logic mb, input logic [3:0] fs,
                       input logic md, rw, input logic [3:0] k, input bit push,
                       input logic [3:0] ev, input logic [3:0] es);
        @(negedge clk);
        b2.CW_VALID    = 1'b1;
        b2.ControlWord = {da, aa, ba, mb, fs, md, rw};
        b2.ConstantIn  = k;
        if (push) q2.push_back('{int'(da), {4'h0, ev}, es});
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            b1.CW_VALID = 1'b0;
            b2.CW_VALID = 1'b0;
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (b1.WB_VALID === 1'b1) begin
            exp_t e;
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb1 unexpected writeback");
            end else begin
                e = q1.pop_front();
                chk($sformatf("wb1 R%0d", e.r), 64'(b1.RegFlat[e.r*8 +: 8]), 64'(e.v));
                chk($sformatf("wb1 status R%0d", e.r), 64'(b1.Status), 64'(e.s));
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (b2.WB_VALID === 1'b1) begin
            exp_t e;
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb2 unexpected writeback");
            end else begin
                e = q2.pop_front();
                chk($sformatf("wb2 R%0d", e.r), 64'(b2.RegFlat[e.r*4 +: 4]), 64'(e.v[3:0]));
                chk($sformatf("wb2 status R%0d", e.r), 64'(b2.Status), 64'(e.s));
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        b1.CW_VALID = 1'b0; b1.ControlWord = '0; b1.ConstantIn = '0; b1.DataIn = '0;
        b2.CW_VALID = 1'b0; b2.ControlWord = '0; b2.ConstantIn = '0; b2.DataIn = '0;
        repeat (2) @(negedge clk);
        chk("reset regs1", b1.RegFlat, 64'h0);
        chk("reset status1", 64'(b1.Status), 64'h0);
        chk("reset addr_valid1", 64'(b1.ADDR_VALID), 64'h0);
        chk("reset wb_valid1", 64'(b1.WB_VALID), 64'h0);
        chk("reset regs2", b2.RegFlat, 64'h0);
        rst = 1'b0;
        // reset in the middle of an instruction drops it
        op1(3, 0, 0, 1, 4'b1100, 0, 1, 8'h5A, 1, 8'h5A, 4'b0000);
        op1(5, 0, 0, 1, 4'b1100, 0, 1, 8'h11, 0, 8'h00, 4'b0000);
        @(negedge clk);
        rst = 1'b1; b1.CW_VALID = 1'b0;
        @(negedge clk);
        chk("midrst regs", b1.RegFlat, 64'h0);
        chk("midrst status", 64'(b1.Status), 64'h0);
        chk("midrst addr_valid", 64'(b1.ADDR_VALID), 64'h0);
        chk("midrst wb_valid", 64'(b1.WB_VALID), 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("dropped write", b1.RegFlat, 64'h0);
        chk("dropped wb_valid", 64'(b1.WB_VALID), 64'h0);
        // immediate loads + signed-overflowing add
        op1(1, 0, 0, 1, 4'b1100, 0, 1, 8'h7F, 1, 8'h7F, 4'b0000);
        op1(2, 0, 0, 1, 4'b1100, 0, 1, 8'h01, 1, 8'h01, 4'b0000);
        op1(3, 1, 2, 0, 4'b0010, 0, 1, 8'h00, 1, 8'h80, 4'b1010);
        // forwarding chain
        op1(1, 0, 0, 1, 4'b1100, 0, 1, 8'h05, 1, 8'h05, 4'b0000);
        op1(1, 1, 0, 0, 4'b0001, 0, 1, 8'h00, 1, 8'h06, 4'b0000);
        op1(1, 1, 0, 0, 4'b0001, 0, 1, 8'h00, 1, 8'h07, 4'b0000);
        // memory path: status must stay at the R6 load's flags
        op1(1, 0, 0, 1, 4'b1100, 0, 1, 8'h10, 1, 8'h10, 4'b0000);
        op1(6, 0, 0, 1, 4'b1100, 0, 1, 8'h90, 1, 8'h90, 4'b0010);
        op1(4, 1, 0, 1, 4'b0000, 1, 1, 8'h3C, 1, 8'hC3, 4'b0010);
        @(negedge clk);
        chk("mem AddressOut", 64'(b1.AddressOut), 64'h10);
        chk("mem DataOut", 64'(b1.DataOut), 64'h3C);
        chk("mem ADDR_VALID", 64'(b1.ADDR_VALID), 64'h1);
        b1.CW_VALID = 1'b0;
        b1.DataIn = 8'hC3;
        idle(1);
        // subtract, shifts, logic, decrement, zero, add with carry-in
        op1(1, 0, 0, 1, 4'b1100, 0, 1, 8'h03, 1, 8'h03, 4'b0000);
        op1(2, 0, 0, 1, 4'b1100, 0, 1, 8'h03, 1, 8'h03, 4'b0000);
        op1(3, 1, 2, 0, 4'b0101, 0, 1, 8'h00, 1, 8'h00, 4'b0101);
        op1(4, 0, 0, 1, 4'b1110, 0, 1, 8'h81, 1, 8'h02, 4'b0100);
        op1(5, 0, 0, 1, 4'b1101, 0, 1, 8'h81, 1, 8'h40, 4'b0100);
        op1(7, 4, 5, 0, 4'b1010, 0, 1, 8'h00, 1, 8'h42, 4'b0000);
        op1(6, 7, 0, 0, 4'b1011, 0, 1, 8'h00, 1, 8'hBD, 4'b0010);
        op1(2, 0, 0, 0, 4'b0110, 0, 1, 8'h00, 1, 8'hFF, 4'b0010);
        op1(0, 0, 0, 0, 4'b1111, 0, 1, 8'h00, 1, 8'h00, 4'b0001);
        op1(3, 1, 2, 0, 4'b0011, 0, 1, 8'h00, 1, 8'h03, 4'b0100);
        idle(3);
        // W=4, NREG=16 instance
        op2(15, 0, 0, 1, 4'b1100, 0, 1, 4'hA, 1, 4'hA, 4'b0010);
        repeat (2) begin
            @(negedge clk);
            b2.CW_VALID = 1'b0;
            b2.ControlWord = {4'd5, 4'd0, 4'd0, 1'b1, 4'b1100, 1'b0, 1'b1};
            b2.ConstantIn = 4'h3;
        end
        op2(14, 15, 0, 0, 4'b0000, 0, 1, 4'h0, 1, 4'hA, 4'b0010);
        @(negedge clk);
        chk("w4 AddressOut R15", 64'(b2.AddressOut), 64'hA);
        chk("w4 ADDR_VALID", 64'(b2.ADDR_VALID), 64'h1);
        b2.CW_VALID = 1'b0;
        op2(13, 15, 14, 0, 4'b0010, 0, 1, 4'h0, 1, 4'h4, 4'b1100);
        op2(3, 0, 0, 1, 4'b1100, 0, 0, 4'h7, 0, 4'h0, 4'b0000);
        @(negedge clk);
        b2.CW_VALID = 1'b0;
        @(negedge clk);
        chk("w4 rw0 wb_valid", 64'(b2.WB_VALID), 64'h0);
        chk("w4 rw0 R3", 64'(b2.RegFlat[12 +: 4]), 64'h0);
        chk("w4 idle R5", 64'(b2.RegFlat[20 +: 4]), 64'h0);
        chk("w4 rw0 flags", 64'(b2.Status), 64'h0);
        idle(3);
        chk("q1 drained", 64'(q1.size()), 64'h0);
        chk("q2 drained", 64'(q2.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
